// File: rtl/ahb3lite_led_ctrl_pkg.sv
// Shared definitions for the AHB3-Lite LED controller.
// Register offsets, bus encodings and the bus FSM state type.
package led_ctrl_pkg;

    localparam logic [1:0] LED_REG_OUT    = 2'd0;
    localparam logic [1:0] LED_REG_MODE   = 2'd1;
    localparam logic [1:0] LED_REG_PERIOD = 2'd2;
    localparam logic [1:0] LED_REG_TOGGLE = 2'd3;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ERR1 = 2'd1,
        BUS_ERR2 = 2'd2
    } bus_state_t;

endpackage

// File: rtl/ahb3lite_led_ctrl_if.sv
// AHB3-Lite slave port bundle for the LED controller.
// Signal names follow the slave's point of view.
interface ahb3lite_led_ctrl_if #(
    parameter int HADDR_SIZE = 32
);
    logic                  hsel_i;
    logic [HADDR_SIZE-1:0] haddr_i;
    logic [31:0]           hwdata_i;
    logic [31:0]           hrdata_o;
    logic                  hwrite_i;
    logic [2:0]            hsize_i;
    logic [1:0]            htrans_i;
    logic                  hready_i;
    logic                  hreadyout_o;
    logic                  hresp_o;

    modport master (
        output hsel_i, haddr_i, hwdata_i, hwrite_i,
        output hsize_i, htrans_i, hready_i,
        input  hrdata_o, hreadyout_o, hresp_o
    );

    modport slave (
        input  hsel_i, haddr_i, hwdata_i, hwrite_i,
        input  hsize_i, htrans_i, hready_i,
        output hrdata_o, hreadyout_o, hresp_o
    );
endinterface

// File: rtl/ahb3lite_led_ctrl_prescaler.sv
// Shared blink prescaler: counts down a half-period and flips the phase.
// A zero period parks the phase high so blinking channels look static.
module led_blink_prescaler #(
    parameter int g_prescaler_width = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [g_prescaler_width-1:0] period_i,
    input  logic                         load_i,
    output logic                         phase_o
);

    logic [g_prescaler_width-1:0] cnt_q;

    // A software reload takes priority over a natural expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_o <= 1'b1;
        end else if (load_i) begin
            cnt_q   <= period_i;
            phase_o <= 1'b1;
        end else if (period_i == '0) begin
            cnt_q   <= '0;
            phase_o <= 1'b1;
        end else if (cnt_q == '0) begin
            cnt_q   <= period_i;
            phase_o <= ~phase_o;
        end else begin
            cnt_q   <= cnt_q - (g_prescaler_width)'(1);
        end
    end

endmodule

// File: rtl/ahb3lite_led_ctrl.sv
// AHB3-Lite slave driving a bank of LEDs with static or blink modes.
// Holds bus decode, register file, error FSM and the LED output mux.
module ahb3lite_led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int g_channels        = 8,
    parameter int g_prescaler_width = 24,
    parameter int HADDR_SIZE        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ahb3lite_led_ctrl_if.slave    bus,
    output logic [g_channels-1:0] led_o,
    output logic                  blink_phase_o
);

    localparam int ADDR_LSB = (HADDR_SIZE > 3) ? 2 : 0;

    logic                         accept;
    logic                         size_ok;
    logic                         dp_valid;
    logic                         dp_write;
    logic [1:0]                   dp_addr;
    logic                         wr_en;
    logic                         per_load;
    logic [g_channels-1:0]        wd_ch;
    logic [g_prescaler_width-1:0] wd_per;
    logic [g_channels-1:0]        out_q;
    logic [g_channels-1:0]        mode_q;
    logic [g_prescaler_width-1:0] period_q;
    logic [g_prescaler_width-1:0] period_d;
    logic [31:0]                  rdata;
    bus_state_t                   state_q;
    bus_state_t                   state_d;
    logic                         hready_out;
    logic                         hresp;

    assign accept  = bus.hsel_i & bus.hready_i & bus.htrans_i[1];
    assign size_ok = (bus.hsize_i == HSIZE_WORD);

    // Only legal transfers open a data phase; errors go to the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else begin
            dp_valid <= accept & size_ok;
            dp_write <= bus.hwrite_i;
            dp_addr  <= bus.haddr_i[ADDR_LSB +: 2];
        end
    end

    assign wr_en    = dp_valid & dp_write;
    assign wd_ch    = bus.hwdata_i[g_channels-1:0];
    assign wd_per   = bus.hwdata_i[g_prescaler_width-1:0];
    assign per_load = wr_en & (dp_addr == LED_REG_PERIOD);
    assign period_d = per_load ? wd_per : period_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q    <= '0;
            mode_q   <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            unique case (dp_addr)
                LED_REG_OUT:    out_q    <= wd_ch;
                LED_REG_MODE:   mode_q   <= wd_ch;
                LED_REG_PERIOD: period_q <= wd_per;
                LED_REG_TOGGLE: out_q    <= out_q ^ wd_ch;
                default:        out_q    <= out_q;
            endcase
        end
    end

    led_blink_prescaler #(
        .g_prescaler_width (g_prescaler_width)
    ) u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .period_i (period_d),
        .load_i   (per_load),
        .phase_o  (blink_phase_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= (out_q & ~mode_q)
                   | (out_q & mode_q & {g_channels{blink_phase_o}});
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_valid && !dp_write) begin
            unique case (dp_addr)
                LED_REG_OUT:    rdata = 32'(out_q);
                LED_REG_MODE:   rdata = 32'(mode_q);
                LED_REG_PERIOD: rdata = 32'(period_q);
                LED_REG_TOGGLE: rdata = 32'(led_o);
                default:        rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BUS_IDLE;
        else       state_q <= state_d;
    end

    // Two-cycle ERROR: hold off the bus, then release with ERROR still set.
    always_comb begin
        state_d    = state_q;
        hready_out = 1'b1;
        hresp      = 1'b0;
        unique case (state_q)
            BUS_IDLE: begin
                if (accept && !size_ok) state_d = BUS_ERR1;
            end
            BUS_ERR1: begin
                hready_out = 1'b0;
                hresp      = 1'b1;
                state_d    = BUS_ERR2;
            end
            BUS_ERR2: begin
                hresp   = 1'b1;
                state_d = (accept && !size_ok) ? BUS_ERR1 : BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    assign bus.hrdata_o    = rdata;
    assign bus.hreadyout_o = hready_out;
    assign bus.hresp_o     = hresp;

endmodule

// File: tb/tb_ahb3lite_led_ctrl.sv
// Directed bench for ahb3lite_led_ctrl with immediate-assertion checks.
// Inputs change 1 ns after the rising edge and outputs are sampled there.
module tb_ahb3lite_led_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] led;
    logic       phase;
    int         total;
    int         bad;
    logic [31:0] rv;

    localparam logic [11:0] PH_TAB  = 12'b1111_0000_1111;
    localparam logic [11:0] LED_TAB = 12'b1110_0001_1111;

    ahb3lite_led_ctrl_if #(.HADDR_SIZE(32)) bus ();

    assign bus.hready_i = bus.hreadyout_o;

    ahb3lite_led_ctrl #(
        .g_channels        (8),
        .g_prescaler_width (24),
        .HADDR_SIZE        (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .led_o         (led),
        .blink_phase_o (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic [3:0] a, input logic w);
        bus.hsel_i   = 1'b1;
        bus.htrans_i = 2'b10;
        bus.haddr_i  = {28'd0, a};
        bus.hwrite_i = w;
        bus.hsize_i  = 3'b010;
    endtask

    task automatic idle_bus();
        bus.hsel_i   = 1'b0;
        bus.htrans_i = 2'b00;
        bus.hwrite_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr_ph(a, 1'b1);
        tick();
        idle_bus();
        bus.hwdata_i = d;
        tick();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        addr_ph(a, 1'b0);
        tick();
        idle_bus();
        d = bus.hrdata_o;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.hsel_i   = 1'b0;
        bus.htrans_i = 2'b00;
        bus.haddr_i  = '0;
        bus.hwdata_i = '0;
        bus.hwrite_i = 1'b0;
        bus.hsize_i  = 3'b010;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready", 32'(bus.hreadyout_o), 32'd1);
        chk("rst_resp", 32'(bus.hresp_o), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_phase", 32'(phase), 32'd1);
        chk("rst_rdata", bus.hrdata_o, 32'd0);
        rd(4'h0, rv); chk("rst_rd_out", rv, 32'd0);
        rd(4'h4, rv); chk("rst_rd_mode", rv, 32'd0);
        rd(4'h8, rv); chk("rst_rd_per", rv, 32'd0);
        rd(4'hC, rv); chk("rst_rd_tog", rv, 32'd0);

        wr(4'h0, 32'hA5);
        tick();
        chk("out_led", 32'(led), 32'hA5);
        rd(4'hC, rv); chk("out_rd_tog", rv, 32'hA5);
        rd(4'h0, rv); chk("out_rd_out", rv, 32'hA5);

        wr(4'hC, 32'h0F);
        tick();
        chk("tog_led", 32'(led), 32'hAA);
        rd(4'h0, rv); chk("tog_rd_out", rv, 32'hAA);

        // write OUT then read TOGGLE back to back
        addr_ph(4'h0, 1'b1);
        tick();
        bus.hwdata_i = 32'h3C;
        addr_ph(4'hC, 1'b0);
        tick();
        idle_bus();
        chk("lag_rd_tog", bus.hrdata_o, 32'hAA);
        tick();
        chk("lag_led", 32'(led), 32'h3C);

        wr(4'h0, 32'hFFFF_FF5A);
        rd(4'h0, rv); chk("wide_rd_out", rv, 32'h5A);

        // MODE=1, OUT=0x81, PERIOD=3 back to back
        addr_ph(4'h4, 1'b1);
        tick();
        bus.hwdata_i = 32'h01;
        addr_ph(4'h0, 1'b1);
        tick();
        bus.hwdata_i = 32'h81;
        addr_ph(4'h8, 1'b1);
        tick();
        bus.hwdata_i = 32'h03;
        idle_bus();
        tick();
        chk("blink_ph0", 32'(phase), 32'(PH_TAB[0]));
        chk("blink_led0", 32'(led), {31'd0, LED_TAB[0]} | 32'h80);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk("blink_ph", 32'(phase), 32'(PH_TAB[k]));
            chk("blink_led", 32'(led), {31'd0, LED_TAB[k]} | 32'h80);
        end
        rd(4'h8, rv); chk("blink_rd_per", rv, 32'd3);
        rd(4'h4, rv); chk("blink_rd_mode", rv, 32'd1);

        wr(4'h8, 32'd0);
        chk("p0_phase", 32'(phase), 32'd1);
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("p0_led", 32'(led), 32'h81);
            chk("p0_ph", 32'(phase), 32'd1);
        end

        // byte write: ERROR response, no register change
        addr_ph(4'h0, 1'b1);
        bus.hsize_i = 3'b000;
        tick();
        chk("err1_ready", 32'(bus.hreadyout_o), 32'd0);
        chk("err1_resp", 32'(bus.hresp_o), 32'd1);
        idle_bus();
        bus.hsize_i  = 3'b010;
        bus.hwdata_i = 32'hFF;
        tick();
        chk("err2_ready", 32'(bus.hreadyout_o), 32'd1);
        chk("err2_resp", 32'(bus.hresp_o), 32'd1);
        bus.hwdata_i = 32'h0;
        tick();
        chk("errx_ready", 32'(bus.hreadyout_o), 32'd1);
        chk("errx_resp", 32'(bus.hresp_o), 32'd0);
        rd(4'h0, rv); chk("err_rd_out", rv, 32'h81);

        // running counter restarted by a back-to-back PERIOD write
        wr(4'h8, 32'd5);
        for (int k = 0; k < 6; k++) tick();
        chk("rs_phase_lo", 32'(phase), 32'd0);
        addr_ph(4'h0, 1'b1);
        tick();
        bus.hwdata_i = 32'h0F;
        addr_ph(4'h4, 1'b1);
        tick();
        bus.hwdata_i = 32'hF0;
        addr_ph(4'h8, 1'b1);
        tick();
        bus.hwdata_i = 32'h02;
        idle_bus();
        tick();
        chk("rs_phase_hi", 32'(phase), 32'd1);
        rd(4'h0, rv); chk("rs_rd_out", rv, 32'h0F);
        rd(4'h4, rv); chk("rs_rd_mode", rv, 32'hF0);
        rd(4'h8, rv); chk("rs_rd_per", rv, 32'd2);
        chk("rs_led", 32'(led), 32'h0F);

        // reset while blinking and inside ERR1
        wr(4'h4, 32'h01);
        wr(4'h0, 32'h01);
        wr(4'h8, 32'h01);
        tick();
        tick();
        tick();
        addr_ph(4'h4, 1'b1);
        bus.hsize_i = 3'b001;
        tick();
        chk("rst_in_err1", 32'(bus.hreadyout_o), 32'd0);
        rst = 1'b1;
        idle_bus();
        bus.hsize_i = 3'b010;
        tick();
        chk("mr_ready", 32'(bus.hreadyout_o), 32'd1);
        chk("mr_resp", 32'(bus.hresp_o), 32'd0);
        chk("mr_led", 32'(led), 32'd0);
        chk("mr_phase", 32'(phase), 32'd1);
        chk("mr_rdata", bus.hrdata_o, 32'd0);
        rst = 1'b0;
        tick();
        rd(4'h4, rv); chk("mr_rd_mode", rv, 32'd0);
        rd(4'h8, rv); chk("mr_rd_per", rv, 32'd0);
        rd(4'h0, rv); chk("mr_rd_out", rv, 32'd0);
        chk("mr_phase2", 32'(phase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
